// File: rtl/cpu15_pkg.sv
// cpu15_pkg: shared widths, opcodes and sequencer state encoding for the 15-bit CPU
package cpu15_pkg;
  localparam int PC_W = 8;
  localparam int INSN_W = 15;
  localparam logic [3:0] OP_MOV = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_SL  = 4'b0101;
  localparam logic [3:0] OP_SR  = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_LDL = 4'b1000;
  localparam logic [3:0] OP_LDH = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_JE  = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LD  = 4'b1101;
  localparam logic [3:0] OP_ST  = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;
  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_FT   = 6'b000010,
    S_DC   = 6'b000100,
    S_EX   = 6'b001000,
    S_WB   = 6'b010000,
    S_HLT  = 6'b100000
  } seq_state_t;
endpackage

// File: rtl/phase_pc_seq.sv
// phase_pc_seq: one-hot phase strobe generator, program counter and retire counter
module phase_pc_seq
  import cpu15_pkg::*;
#(
  parameter int PC_WIDTH = PC_W,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 RUN,
  input  logic                 STEP,
  input  logic                 JUMP_EN,
  input  logic [PC_WIDTH-1:0]  JUMP_ADDR,
  input  logic                 HALT_REQ,
  output logic                 CLK_FT,
  output logic                 CLK_DC,
  output logic                 CLK_EX,
  output logic                 CLK_WB,
  output logic [PC_WIDTH-1:0]  P_COUNT,
  output logic                 BUSY,
  output logic                 HALTED,
  output logic [CNT_WIDTH-1:0] INSN_CNT
);
  seq_state_t state, state_nx;
  // State register; the strobes are taken straight from these flops
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) state <= S_IDLE;
    else state <= state_nx;
  // Next state: fixed four-phase walk, WB decides halt/continue/idle, HLT is sticky
  always_comb begin
    state_nx = S_IDLE;
    case (state)
      S_IDLE:  state_nx = (RUN || STEP) ? S_FT : S_IDLE;
      S_FT:    state_nx = S_DC;
      S_DC:    state_nx = S_EX;
      S_EX:    state_nx = S_WB;
      S_WB:    state_nx = HALT_REQ ? S_HLT : (RUN ? S_FT : S_IDLE);
      S_HLT:   state_nx = S_HLT;
      default: state_nx = S_IDLE;
    endcase
  end
  // Phase outputs decoded directly from the one-hot state bits
  always_comb begin
    CLK_FT = state[1];
    CLK_DC = state[2];
    CLK_EX = state[3];
    CLK_WB = state[4];
    HALTED = state[5];
    BUSY   = |state[4:1];
  end
  // PC and retire counter move only on the edge that ends WB; a halt freezes the PC
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      P_COUNT  <= RESET_PC;
      INSN_CNT <= '0;
    end else if (state == S_WB) begin
      if (!HALT_REQ) P_COUNT <= JUMP_EN ? JUMP_ADDR : P_COUNT + 1'b1;
      if (!(&INSN_CNT)) INSN_CNT <= INSN_CNT + 1'b1;
    end
endmodule

// File: tb/tb_phase_pc_seq.sv
// tb_phase_pc_seq: directed-vector bench for the phase/PC sequencer
module tb_phase_pc_seq;
  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        RUN = 1'b0;
  logic        STEP = 1'b0;
  logic        JUMP_EN = 1'b0;
  logic [7:0]  JUMP_ADDR = 8'h00;
  logic        HALT_REQ = 1'b0;
  logic        CLK_FT, CLK_DC, CLK_EX, CLK_WB, BUSY, HALTED;
  logic [7:0]  P_COUNT;
  logic [15:0] INSN_CNT;
  int total = 0;
  int bad = 0;

  phase_pc_seq dut (
    .CLK(CLK), .RESET_N(RESET_N), .RUN(RUN), .STEP(STEP),
    .JUMP_EN(JUMP_EN), .JUMP_ADDR(JUMP_ADDR), .HALT_REQ(HALT_REQ),
    .CLK_FT(CLK_FT), .CLK_DC(CLK_DC), .CLK_EX(CLK_EX), .CLK_WB(CLK_WB),
    .P_COUNT(P_COUNT), .BUSY(BUSY), .HALTED(HALTED), .INSN_CNT(INSN_CNT)
  );

  always #5 CLK = ~CLK;

  wire [3:0] stb = {CLK_FT, CLK_DC, CLK_EX, CLK_WB};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  // One instruction: checks each phase, optionally drives a jump in EX, jump/halt in WB,
  // a STEP pulse in DC, and sets RUN during DC.
  task automatic insn(input logic [7:0] pc, input logic [15:0] cnt, input logic j_ex,
                      input logic j_wb, input logic [7:0] addr, input logic hlt,
                      input logic run_after, input logic stp_dc);
    cyc();
    JUMP_EN = 1'b0; HALT_REQ = 1'b0; STEP = 1'b0;
    chk("ft_strobe", 32'(stb), 32'(4'b1000));
    chk("ft_pc", 32'(P_COUNT), 32'(pc));
    chk("ft_cnt", 32'(INSN_CNT), 32'(cnt));
    chk("ft_busy", 32'(BUSY), 32'd1);
    cyc();
    chk("dc_strobe", 32'(stb), 32'(4'b0100));
    RUN = run_after;
    STEP = stp_dc;
    cyc();
    chk("ex_strobe", 32'(stb), 32'(4'b0010));
    STEP = 1'b0;
    if (j_ex) begin JUMP_EN = 1'b1; JUMP_ADDR = addr; end
    cyc();
    chk("wb_strobe", 32'(stb), 32'(4'b0001));
    chk("wb_pc_stable", 32'(P_COUNT), 32'(pc));
    JUMP_EN = j_wb; JUMP_ADDR = addr; HALT_REQ = hlt;
  endtask

  initial begin
    #12;
    chk("rst_strobe", 32'(stb), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_pc", 32'(P_COUNT), 32'h00);
    chk("rst_halted", 32'(HALTED), 32'd0);
    chk("rst_cnt", 32'(INSN_CNT), 32'd0);
    cyc();
    RESET_N = 1'b1; RUN = 1'b1;
    insn(8'h00, 16'd0, 0, 0, 8'h00, 0, 1, 0);
    insn(8'h01, 16'd1, 0, 0, 8'h00, 0, 1, 0);
    insn(8'h02, 16'd2, 0, 0, 8'h00, 0, 1, 0);
    insn(8'h03, 16'd3, 0, 1, 8'h0D, 0, 1, 0);
    insn(8'h0D, 16'd4, 0, 1, 8'h08, 0, 1, 0);
    insn(8'h08, 16'd5, 0, 1, 8'h0D, 0, 1, 0);
    insn(8'h0D, 16'd6, 1, 0, 8'h08, 0, 1, 0);
    insn(8'h0E, 16'd7, 0, 1, 8'hFF, 0, 1, 0);
    insn(8'hFF, 16'd8, 0, 0, 8'h00, 0, 1, 0);
    insn(8'h00, 16'd9, 0, 1, 8'h0E, 0, 1, 0);
    insn(8'h0E, 16'd10, 0, 0, 8'h00, 0, 0, 0);
    cyc();
    chk("idle_strobe", 32'(stb), 32'd0);
    chk("idle_busy", 32'(BUSY), 32'd0);
    chk("idle_pc", 32'(P_COUNT), 32'h0F);
    chk("idle_cnt", 32'(INSN_CNT), 32'd11);
    cyc();
    chk("idle_hold", 32'(stb), 32'd0);
    STEP = 1'b1;
    insn(8'h0F, 16'd11, 0, 0, 8'h00, 0, 0, 1);
    cyc();
    chk("step_idle_strobe", 32'(stb), 32'd0);
    chk("step_idle_busy", 32'(BUSY), 32'd0);
    chk("step_pc", 32'(P_COUNT), 32'h10);
    chk("step_cnt", 32'(INSN_CNT), 32'd12);
    cyc();
    chk("step_dc_ignored", 32'(stb), 32'd0);
    RUN = 1'b1;
    insn(8'h10, 16'd12, 0, 1, 8'h0E, 0, 1, 0);
    insn(8'h0E, 16'd13, 0, 1, 8'h33, 1, 1, 0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      JUMP_EN = 1'b0; HALT_REQ = 1'b0;
      STEP = i[0];
      chk("hlt_strobe", 32'(stb), 32'd0);
      chk("hlt_busy", 32'(BUSY), 32'd0);
      chk("hlt_halted", 32'(HALTED), 32'd1);
      chk("hlt_pc", 32'(P_COUNT), 32'h0E);
      chk("hlt_cnt", 32'(INSN_CNT), 32'd14);
    end
    cyc();
    STEP = 1'b0;
    RESET_N = 1'b0;
    #1;
    chk("hlt_rst_halted", 32'(HALTED), 32'd0);
    chk("hlt_rst_cnt", 32'(INSN_CNT), 32'd0);
    cyc();
    RESET_N = 1'b1;
    insn(8'h00, 16'd0, 0, 1, 8'h55, 0, 1, 0);
    cyc();
    JUMP_EN = 1'b0;
    chk("pre_rst_ft", 32'(stb), 32'(4'b1000));
    chk("pre_rst_pc", 32'(P_COUNT), 32'h55);
    cyc();
    cyc();
    chk("pre_rst_ex", 32'(stb), 32'(4'b0010));
    chk("pre_rst_cnt", 32'(INSN_CNT), 32'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("async_rst_strobe", 32'(stb), 32'd0);
    chk("async_rst_busy", 32'(BUSY), 32'd0);
    chk("async_rst_pc", 32'(P_COUNT), 32'h00);
    chk("async_rst_cnt", 32'(INSN_CNT), 32'd0);
    cyc();
    chk("rst_held_strobe", 32'(stb), 32'd0);
    RESET_N = 1'b1;
    cyc();
    chk("restart_ft", 32'(stb), 32'(4'b1000));
    chk("restart_pc", 32'(P_COUNT), 32'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
